// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: walks the program counter through fetch/execute,
// with a bounded memory wait, deferred halt requests and a saturating retire count.
module pc_sequencer #(
   parameter int ADDR_WIDTH    = 8,
   parameter int REG_BIT_CNT   = 2,
   parameter int DATA_WIDTH    = 8,
   parameter int COMBINED_DATA = ADDR_WIDTH + REG_BIT_CNT + DATA_WIDTH,
   parameter int TIMEOUT       = 15
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     halt_req,
   output logic                     mem_req,
   output logic [ADDR_WIDTH-1:0]    mem_addr,
   input  logic                     mem_ack,
   input  logic [COMBINED_DATA-1:0] mem_rdata,
   output logic [COMBINED_DATA-1:0] instr,
   output logic                     instr_valid,
   input  logic                     exec_done,
   input  logic                     branch_taken,
   input  logic [ADDR_WIDTH-1:0]    branch_target,
   output logic [ADDR_WIDTH-1:0]    pc,
   output logic                     halted,
   output logic                     fault,
   output logic [15:0]              retired
);

   typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

   state_t                    state, state_nxt;
   logic [ADDR_WIDTH-1:0]     pc_nxt;
   logic [COMBINED_DATA-1:0]  instr_nxt;
   logic [15:0]               retired_nxt;
   logic                      fault_nxt;
   logic                      halt_pending, halt_pending_nxt;
   logic [7:0]                wait_cnt, wait_cnt_nxt;
   logic [7:0]                wait_inc;

   assign wait_inc = wait_cnt + 8'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         pc           <= '0;
         instr        <= '0;
         retired      <= '0;
         fault        <= 1'b0;
         halt_pending <= 1'b0;
         wait_cnt     <= '0;
      end else begin
         state        <= state_nxt;
         pc           <= pc_nxt;
         instr        <= instr_nxt;
         retired      <= retired_nxt;
         fault        <= fault_nxt;
         halt_pending <= halt_pending_nxt;
         wait_cnt     <= wait_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      pc_nxt           = pc;
      instr_nxt        = instr;
      retired_nxt      = retired;
      fault_nxt        = fault;
      halt_pending_nxt = halt_pending;
      wait_cnt_nxt     = wait_cnt;
      case (state)
         IDLE: begin
            if (halt_req) begin
               state_nxt = HALT;
            end else if (start) begin
               state_nxt    = FETCH;
               wait_cnt_nxt = '0;
            end
         end
         FETCH: begin
            if (halt_req) halt_pending_nxt = 1'b1;
            // an ack arriving on the final permitted wait cycle still wins over the timeout
            if (mem_ack) begin
               instr_nxt = mem_rdata;
               state_nxt = EXEC;
            end else if (wait_inc == 8'(TIMEOUT)) begin
               fault_nxt        = 1'b1;
               halt_pending_nxt = 1'b0;
               state_nxt        = HALT;
            end else begin
               wait_cnt_nxt = wait_inc;
            end
         end
         EXEC: begin
            if (halt_req) halt_pending_nxt = 1'b1;
            if (exec_done) begin
               pc_nxt      = branch_taken ? branch_target : pc + ADDR_WIDTH'(1);
               retired_nxt = (retired == 16'hFFFF) ? retired : retired + 16'd1;
               if (halt_pending || halt_req) begin
                  halt_pending_nxt = 1'b0;
                  state_nxt        = HALT;
               end else begin
                  wait_cnt_nxt = '0;
                  state_nxt    = FETCH;
               end
            end
         end
         HALT: begin
            if (start) begin
               fault_nxt        = 1'b0;
               halt_pending_nxt = 1'b0;
               wait_cnt_nxt     = '0;
               state_nxt        = FETCH;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign mem_req     = (state == FETCH);
   assign mem_addr    = pc;
   assign instr_valid = (state == EXEC);
   assign halted      = (state == HALT);

endmodule
